// File: rtl/io_input_ctrl.sv
// io_input_ctrl: memory-mapped input peripheral behind the LSU read port.
// Synchronises switches and buttons, debounces buttons, latches button-press
// events as sticky read-to-clear bits and answers LSU reads with a fixed
// two-cycle request/acknowledge sequence.
module io_input_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int NBTN       = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [31:0]     i_io_sw,
    input  logic [NBTN-1:0] i_io_btn,
    input  logic            i_rd_req,
    input  logic [15:0]     i_addr,
    output logic [31:0]     o_rd_data,
    output logic            o_rd_ack,
    output logic            o_evt_pending
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    // Word addresses (byte offset bits masked off before decode)
    localparam logic [15:0] ADDR_SW   = 16'h7800;
    localparam logic [15:0] ADDR_BTN  = 16'h7810;
    localparam logic [15:0] ADDR_STAT = 16'h7820;
    localparam logic [15:0] ADDR_EVT  = 16'h7830;
    localparam logic [15:0] WORD_MASK = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [31:0]      sw_meta_r;
    logic [31:0]      sw_sync_r;
    logic [NBTN-1:0]  btn_meta_r;
    logic [NBTN-1:0]  btn_sync_r;
    logic [NBTN-1:0]  btn_deb_r;
    logic [CNT_W-1:0] deb_cnt_r [NBTN];
    logic [CNT_W-1:0] cnt_next_s [NBTN];
    logic [NBTN-1:0]  deb_next_s;
    logic [NBTN-1:0]  rise_s;
    logic [NBTN-1:0]  evt_r;
    logic [NBTN-1:0]  evt_next_s;
    logic             evt_pending_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [15:0]      addr_r;
    logic [15:0]      addr_word_s;
    logic [31:0]      sel_data_s;
    logic [31:0]      data_r;
    logic [NBTN-1:0]  clr_mask_s;
    logic [NBTN-1:0]  clr_mask_r;
    logic             ack_r;

    // Two-flop synchronisers for every raw switch and button pin
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_meta_r  <= 32'd0;
            sw_sync_r  <= 32'd0;
            btn_meta_r <= {NBTN{1'b0}};
            btn_sync_r <= {NBTN{1'b0}};
        end else begin
            sw_meta_r  <= i_io_sw;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= i_io_btn;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip once the run is long enough
    always_comb begin
        deb_next_s = btn_deb_r;
        for (int i = 0; i < NBTN; i++) begin
            cnt_next_s[i] = {CNT_W{1'b0}};
            if (btn_sync_r[i] != btn_deb_r[i]) begin
                if (deb_cnt_r[i] == CNT_LAST) begin
                    deb_next_s[i] = ~btn_deb_r[i];
                    cnt_next_s[i] = {CNT_W{1'b0}};
                end else begin
                    cnt_next_s[i] = deb_cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_next_s[i] = {CNT_W{1'b0}};
            end
        end
    end

    assign rise_s = deb_next_s & ~btn_deb_r;

    // Debounce state and counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_deb_r <= {NBTN{1'b0}};
            for (int i = 0; i < NBTN; i++) begin
                deb_cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            btn_deb_r <= deb_next_s;
            for (int i = 0; i < NBTN; i++) begin
                deb_cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Event update: the read clear applies only in RESP, and new presses always win
    always_comb begin
        if (state_r == ST_RESP) begin
            evt_next_s = (evt_r & ~clr_mask_r) | rise_s;
        end else begin
            evt_next_s = evt_r | rise_s;
        end
    end

    // Sticky event bits and the registered pending flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            evt_r         <= {NBTN{1'b0}};
            evt_pending_r <= 1'b0;
        end else begin
            evt_r         <= evt_next_s;
            evt_pending_r <= |evt_r;
        end
    end

    assign addr_word_s = addr_r & WORD_MASK;

    // Read-data mux and events clear mask for the latched address
    always_comb begin
        sel_data_s = 32'd0;
        clr_mask_s = {NBTN{1'b0}};
        case (addr_word_s)
            ADDR_SW:   sel_data_s = sw_sync_r;
            ADDR_BTN:  sel_data_s[NBTN-1:0] = btn_deb_r;
            ADDR_STAT: sel_data_s[0] = evt_pending_r;
            ADDR_EVT: begin
                sel_data_s[NBTN-1:0] = evt_r;
                clr_mask_s           = evt_r;
            end
            default:   sel_data_s = 32'd0;
        endcase
    end

    // Read FSM next-state: IDLE -> CAPT -> RESP -> IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_rd_req) begin
                    state_next_s = ST_CAPT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CAPT: state_next_s = ST_RESP;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, address latch, captured data, clear mask and acknowledge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= 16'd0;
            data_r     <= 32'd0;
            clr_mask_r <= {NBTN{1'b0}};
            ack_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && i_rd_req) begin
                addr_r <= i_addr;
            end
            if (state_r == ST_CAPT) begin
                data_r     <= sel_data_s;
                clr_mask_r <= clr_mask_s;
            end else begin
                data_r <= 32'd0;
            end
            ack_r <= (state_r == ST_CAPT);
        end
    end

    assign o_rd_data     = data_r;
    assign o_rd_ack      = ack_r;
    assign o_evt_pending = evt_pending_r;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Testbench for io_input_ctrl: directed steps from the test plan followed by
// randomized button/switch activity and reads, checked against a pin-history
// reference model.
module tb_io_input_ctrl;

    localparam int DEB = 4;
    localparam int NB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   sw;
    logic [NB-1:0] btn;
    logic          req;
    logic [15:0]   addr;
    logic [31:0]   rd_data;
    logic          ack;
    logic          pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_input_ctrl #(.DEB_CYCLES(DEB), .NBTN(NB)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_io_sw       (sw),
        .i_io_btn      (btn),
        .i_rd_req      (req),
        .i_addr        (addr),
        .o_rd_data     (rd_data),
        .o_rd_ack      (ack),
        .o_evt_pending (pend)
    );

    // Reference model: history of pin samples; entry 1 is what the design
    // sees after two synchroniser stages. A button flips when the last DEB
    // synchronised samples all disagree with its debounced state.
    logic [31:0]   sw_h  [0:DEB+1];
    logic [NB-1:0] btn_h [0:DEB+1];
    logic [NB-1:0] deb_m;
    logic [NB-1:0] evt_m;
    logic          pend_m;
    logic [NB-1:0] clr_m = '0;

    function automatic logic [NB-1:0] flip_m();
        logic [NB-1:0] f;
        for (int k = 0; k < NB; k++) begin
            f[k] = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (btn_h[j][k] == deb_m[k]) f[k] = 1'b0;
            end
        end
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j <= DEB + 1; j++) begin
                sw_h[j]  <= '0;
                btn_h[j] <= '0;
            end
            deb_m  <= '0;
            evt_m  <= '0;
            pend_m <= 1'b0;
        end else begin
            sw_h[0]  <= sw;
            btn_h[0] <= btn;
            for (int j = 1; j <= DEB + 1; j++) begin
                sw_h[j]  <= sw_h[j-1];
                btn_h[j] <= btn_h[j-1];
            end
            deb_m  <= deb_m ^ flip_m();
            evt_m  <= (evt_m & ~clr_m) | (flip_m() & ~deb_m);
            pend_m <= |evt_m;
        end
    end

    function automatic logic [31:0] exp_val(input logic [15:0] a);
        logic [31:0] v;
        case (a & 16'hFFFC)
            16'h7800: v = sw_h[1];
            16'h7810: v = 32'(deb_m);
            16'h7820: v = {31'd0, pend_m};
            16'h7830: v = 32'(evt_m);
            default:  v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One read: request accepted at the next edge, ack two cycles later
    task automatic do_read(input logic [15:0] a, output logic [31:0] got);
        logic [31:0]   exp;
        logic [NB-1:0] mask;
        req  = 1'b1;
        addr = a;
        tick();
        req  = 1'b0;
        exp  = exp_val(a);
        mask = ((a & 16'hFFFC) == 16'h7830) ? evt_m : '0;
        check("ack_capt", {31'd0, ack}, 32'd0);
        check("data_capt", rd_data, 32'd0);
        tick();
        check("ack_resp", {31'd0, ack}, 32'd1);
        check("data_resp", rd_data, exp);
        got   = rd_data;
        clr_m = mask;
        tick();
        clr_m = '0;
        check("ack_after", {31'd0, ack}, 32'd0);
        check("data_after", rd_data, 32'd0);
        check("pending", {31'd0, pend}, {31'd0, pend_m});
    endtask

    logic [31:0] got;
    logic [15:0] addr_tab [0:5];
    logic        exp_ack;

    initial begin
        addr_tab[0] = 16'h7800; addr_tab[1] = 16'h7810; addr_tab[2] = 16'h7820;
        addr_tab[3] = 16'h7830; addr_tab[4] = 16'h7840; addr_tab[5] = 16'h0000;
        rst = 1'b1; sw = 32'd0; btn = '0; req = 1'b0; addr = 16'd0;
        ticks(2);
        rst = 1'b0;
        check("rst_data", rd_data, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_pend", {31'd0, pend}, 32'd0);

        // Switch read
        sw = 32'hA5A5_0F0F;
        ticks(3);
        do_read(16'h7800, got);
        check("sw_value", got, 32'hA5A5_0F0F);

        // Three-cycle glitch must not debounce
        btn = 4'b0001; ticks(3);
        btn = 4'b0000; ticks(8);
        do_read(16'h7810, got);
        check("glitch_btn", got, 32'd0);
        check("glitch_pend", {31'd0, pend}, 32'd0);

        // Held press: flip at edge 6 after the pin edge, pending one edge later
        btn = 4'b0001;
        ticks(6);
        check("deb_pend_early", {31'd0, pend}, 32'd0);
        tick();
        check("deb_pend_set", {31'd0, pend}, 32'd1);
        do_read(16'h7810, got);
        check("btn_read", got, 32'd1);
        do_read(16'h7820, got);
        check("status_read", got, 32'd1);

        // btn2 debounces in the RESP cycle of an events read
        btn = 4'b0101;
        ticks(3);
        do_read(16'h7830, got);
        check("collide_first", got, 32'd1);
        do_read(16'h7830, got);
        check("collide_second", got, 32'd4);

        // Read-to-clear with btn1 and btn3
        btn = 4'b1011;
        ticks(10);
        do_read(16'h7830, got);
        check("evt_read", got, 32'hA);
        tick();
        check("evt_pend_fall", {31'd0, pend}, 32'd0);
        do_read(16'h7830, got);
        check("evt_reread", got, 32'd0);

        // Unmapped address
        do_read(16'h7840, got);
        check("unmapped", got, 32'd0);

        // Request held: acks at N+2, N+5, N+8
        req = 1'b1; addr = 16'h7800;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_ack = (k == 2) || (k == 5) || (k == 8);
            check("b2b_ack", {31'd0, ack}, {31'd0, exp_ack});
            check("b2b_data", rd_data, exp_ack ? 32'hA5A5_0F0F : 32'd0);
        end
        req = 1'b0;
        tick();

        // Reset in CAPT: no ack, events lost, immediate new acceptance
        btn = 4'b0000; ticks(10);
        btn = 4'b0001; ticks(10);
        btn = 4'b0000; ticks(10);
        check("pre_rst_pend", {31'd0, pend}, 32'd1);
        req = 1'b1; addr = 16'h7830;
        tick();
        rst = 1'b1; req = 1'b0;
        tick();
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_pend", {31'd0, pend}, 32'd0);
        rst = 1'b0;
        do_read(16'h7830, got);
        check("midrst_evt", got, 32'd0);

        // Randomized activity against the model
        for (int it = 0; it < 40; it++) begin
            sw  = $urandom;
            btn = NB'($urandom_range(0, (1 << NB) - 1));
            ticks($urandom_range(0, 8));
            do_read(addr_tab[$urandom_range(0, 5)] | 16'($urandom_range(0, 3)), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_input_ctrl.md
Name: io_input_ctrl

Overview:
- Controller for the memory-mapped input peripheral (switches, push-buttons, status flag) behind the LSU read port.
- Synchronises and debounces the raw board inputs and latches button-press events as sticky, read-to-clear bits.
- Sequences LSU read requests through a fixed-latency request/acknowledge handshake.
- Sits between the board pins and the LSU read-data mux; replaces ad-hoc always-enabled capture registers.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles needed before a button's debounced state changes (≥1).
- NBTN, 4, number of push-buttons (≤32).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_io_sw  input  32  raw switch inputs (asynchronous to i_clk)
- i_io_btn  input  NBTN  raw button inputs, active-high (asynchronous)
- i_rd_req  input  1  LSU read request; level, held until o_rd_ack
- i_addr  input  16  LSU byte address, valid while i_rd_req=1
- o_rd_data  output  32  read data, valid only while o_rd_ack=1
- o_rd_ack  output  1  one-cycle read acknowledge
- o_evt_pending  output  1  OR of all event bits (interrupt/poll hint)

Behaviour:
- Reset: synchronous on i_rst=1 at a rising i_clk. Clears synchroniser flops, debounce counters, debounced states, event bits and FSM (→IDLE). Outputs after reset: o_rd_data=0, o_rd_ack=0, o_evt_pending=0.
- Synchronisers: 2-flop synchroniser on every bit of i_io_sw and i_io_btn. Switch value = second-stage output; no debounce on switches.
- Debounce, per button:
  - Counter increments while the synchronised value differs from the debounced state; any cycle where they are equal resets the counter to 0.
  - When the counter reaches DEB_CYCLES-1 and they still differ, the debounced state flips and the counter clears.
  - Raw-pin-to-debounced latency = 2 + DEB_CYCLES cycles.
- Events: a 0→1 flip of debounced button k sets evt[k] (sticky). A 1→0 flip sets nothing.
- Address map, decoded on i_addr[15:2] (i_addr[1:0] ignored):
  - 0x7800 switches: 32-bit synchronised value.
  - 0x7810 buttons: debounced states, zero-extended.
  - 0x7820 status: bit0 = o_evt_pending, rest 0.
  - 0x7830 events: evt, zero-extended; read-to-clear.
  - Any other address returns 0 and is still acknowledged.
- Read FSM, states IDLE, CAPT, RESP:
  - IDLE: if i_rd_req=1, latch i_addr → CAPT; else stay.
  - CAPT: select the addressed value into the data register; for the events address, also record the clear mask = evt value returned → RESP.
  - RESP: o_rd_ack=1 for exactly this cycle, with o_rd_data = captured value; apply the clear mask → IDLE.
  - Latency: request accepted in cycle N, ack in cycle N+2. Back-to-back reads: next acceptance at N+3 at the earliest.
  - i_rd_req sampled only in IDLE; deasserting it in CAPT/RESP does not abort the read.
- Simultaneous events: an event arriving in the RESP (clear) cycle, or any bit not in the clear mask, remains set (set wins over clear for new events). An event arriving in CAPT after capture stays set and is returned by the next read.
- o_rd_data returns to 0 whenever o_rd_ack=0.
- o_evt_pending is registered from evt: it updates the cycle after evt changes.
- Reset mid-transaction: the FSM returns to IDLE, no ack is issued, and event bits are lost.

Test Plan:
- Reset/switch read: assert i_rst 2 cycles, check all outputs 0. Drive i_io_sw=0xA5A5_0F0F, wait 3 cycles, request 0x7800 → o_rd_ack exactly 2 cycles after acceptance with data 0xA5A5_0F0F; data 0 otherwise.
- Debounce: DEB_CYCLES=4. Toggle btn0 with a 3-cycle glitch → button read 0x0 and no event. Hold btn0 high → debounced bit set at cycle 6 after the edge; read 0x7810 → 0x1; read 0x7820 → 0x1.
- Read-to-clear: press btn1 and btn3, read 0x7830 → 0xA, o_evt_pending falls; second read → 0x0.
- Set/clear collision: btn2 press debounces in the RESP cycle of an events read returning 0x1 → that read returns 0x1, the next read returns 0x4.
- Unmapped/back-to-back: request 0x7840 → ack with 0. Hold i_rd_req continuously on 0x7800 → acks at N+2, N+5, N+8.
- Reset mid-read: assert i_rst in CAPT → no o_rd_ack, evt=0, FSM accepts a new request 1 cycle after reset deasserts.
